// File: rtl/ultrasonic_ranger_pkg.sv
// Shared definitions for the multi-channel ultrasonic ranger: FSM encoding,
// derived-width helper and default 50 MHz timing constants.
package ultrasonic_ranger_pkg;

   localparam int unsigned STATE_W = 3;
   typedef logic [STATE_W-1:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_TRIG      = 3'd1;
   localparam state_t ST_WAIT_RISE = 3'd2;
   localparam state_t ST_MEASURE   = 3'd3;
   localparam state_t ST_DONE      = 3'd4;
   localparam state_t ST_HOLD      = 3'd5;

   localparam int unsigned DEF_NUM_CH         = 2;
   localparam int unsigned DEF_DIST_W         = 9;
   localparam int unsigned DEF_TRIG_CYCLES    = 500;
   localparam int unsigned DEF_PERIOD_CYCLES  = 3000000;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 1500000;
   localparam int unsigned DEF_CYCLES_PER_CM  = 2900;

   // Channel index width; a single sensor still needs a 1-bit index.
   function automatic int unsigned ch_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ultrasonic_ranger_echo_sync.sv
// Per-bit two-flop synchroniser for the asynchronous echo pins.
module ultrasonic_ranger_echo_sync #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         meta <= '0;
         dout <= '0;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end

endmodule

// File: rtl/ultrasonic_ranger.sv
// Round-robin HC-SR04 style ranging engine: one fixed-length slot per sensor,
// trigger pulse, echo timing in cm steps and per-channel result publishing.
module ultrasonic_ranger
   import ultrasonic_ranger_pkg::*;
#(
   parameter int unsigned NUM_CH         = DEF_NUM_CH,
   parameter int unsigned DIST_W         = DEF_DIST_W,
   parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
   parameter int unsigned PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int unsigned CYCLES_PER_CM  = DEF_CYCLES_PER_CM,
   localparam int unsigned CH_W          = ch_width(NUM_CH)
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     enable,
   input  logic [NUM_CH-1:0]        echo,
   output logic [NUM_CH-1:0]        trig,
   output logic [DIST_W-1:0]        distance,
   output logic [CH_W-1:0]          dist_ch,
   output logic                     dist_valid,
   output logic                     dist_timeout,
   output logic [NUM_CH*DIST_W-1:0] dist_all
);

   localparam int unsigned SLOT_W = $clog2(PERIOD_CYCLES);
   localparam int unsigned SUB_W  = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

   localparam logic [SLOT_W-1:0] TRIG_LAST   = SLOT_W'(TRIG_CYCLES - 1);
   localparam logic [SLOT_W-1:0] TMO_LAST    = SLOT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [SLOT_W-1:0] PERIOD_LAST = SLOT_W'(PERIOD_CYCLES - 1);
   localparam logic [SUB_W-1:0]  SUB_LAST    = SUB_W'(CYCLES_PER_CM - 1);
   localparam logic [SUB_W-1:0]  SUB_FIRST   = SUB_W'((CYCLES_PER_CM > 1) ? 1 : 0);
   localparam logic [DIST_W-1:0] CM_FIRST    = DIST_W'((CYCLES_PER_CM > 1) ? 0 : 1);
   localparam logic [DIST_W-1:0] DIST_MAX    = '1;
   localparam logic [CH_W-1:0]   CH_LAST     = CH_W'(NUM_CH - 1);

   state_t                    state_q, state_d;
   logic [CH_W-1:0]           ch_q, ch_d, ch_inc;
   logic [SLOT_W-1:0]         slot_q, slot_d;
   logic [SUB_W-1:0]          sub_q, sub_d;
   logic [DIST_W-1:0]         cm_q, cm_d;
   logic                      tmo_d;
   logic                      slot_end;
   logic                      echo_s;
   logic [NUM_CH-1:0]         echo_sy;

   logic [NUM_CH-1:0]         trig_d;
   logic [DIST_W-1:0]         dist_d, result;
   logic [CH_W-1:0]           dch_d;
   logic                      valid_d, dtmo_d;
   logic [NUM_CH*DIST_W-1:0]  all_d;

   ultrasonic_ranger_echo_sync #(
      .WIDTH (NUM_CH)
   ) u_echo_sync (
      .clock  (clock),
      .resetn (resetn),
      .din    (echo),
      .dout   (echo_sy)
   );

   assign echo_s   = echo_sy[ch_q];
   assign slot_end = (slot_q == PERIOD_LAST);
   assign ch_inc   = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);

   // State, channel pointer and counters.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         ch_q    <= '0;
         slot_q  <= '0;
         sub_q   <= '0;
         cm_q    <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         slot_q  <= slot_d;
         sub_q   <= sub_d;
         cm_q    <= cm_d;
      end
   end

   // Next state; timeout wins over an echo edge seen in the same cycle.
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      tmo_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_TRIG;
         end
         ST_TRIG: begin
            if (slot_q == TRIG_LAST) state_d = ST_WAIT_RISE;
         end
         ST_WAIT_RISE: begin
            if (slot_q == TMO_LAST) begin
               state_d = ST_DONE;
               tmo_d   = 1'b1;
            end else if (echo_s) begin
               state_d = ST_MEASURE;
            end
         end
         ST_MEASURE: begin
            if (slot_q == TMO_LAST) begin
               state_d = ST_DONE;
               tmo_d   = 1'b1;
            end else if (!echo_s) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_HOLD;
            if (slot_end) begin
               ch_d    = ch_inc;
               state_d = enable ? ST_TRIG : ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (slot_end) begin
               ch_d    = ch_inc;
               state_d = enable ? ST_TRIG : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Slot timer and divider-free cm counter; the rising cycle counts as the first high cycle.
   always_comb begin
      slot_d = slot_q;
      sub_d  = sub_q;
      cm_d   = cm_q;
      if (state_d == ST_TRIG && state_q != ST_TRIG) begin
         slot_d = '0;
      end else if (state_q != ST_IDLE) begin
         slot_d = slot_end ? '0 : slot_q + SLOT_W'(1);
      end
      if (state_q == ST_WAIT_RISE && state_d == ST_MEASURE) begin
         sub_d = SUB_FIRST;
         cm_d  = CM_FIRST;
      end else if (state_q == ST_MEASURE && echo_s) begin
         if (sub_q == SUB_LAST) begin
            sub_d = '0;
            if (cm_q != DIST_MAX) cm_d = cm_q + DIST_W'(1);
         end else begin
            sub_d = sub_q + SUB_W'(1);
         end
      end
   end

   // Output decode, registered below so pins change with the state they reflect.
   always_comb begin
      trig_d  = '0;
      valid_d = 1'b0;
      dist_d  = distance;
      dch_d   = dist_ch;
      dtmo_d  = dist_timeout;
      all_d   = dist_all;
      result  = tmo_d ? DIST_MAX : cm_q;
      for (int k = 0; k < NUM_CH; k++) begin
         if (state_d == ST_TRIG && ch_d == CH_W'(k)) trig_d[k] = 1'b1;
      end
      if (state_d == ST_DONE) begin
         valid_d = 1'b1;
         dist_d  = result;
         dch_d   = ch_q;
         dtmo_d  = tmo_d;
         for (int k = 0; k < NUM_CH; k++) begin
            if (ch_q == CH_W'(k)) all_d[k*DIST_W +: DIST_W] = result;
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         trig         <= '0;
         distance     <= '0;
         dist_ch      <= '0;
         dist_valid   <= 1'b0;
         dist_timeout <= 1'b0;
         dist_all     <= '0;
      end else begin
         trig         <= trig_d;
         distance     <= dist_d;
         dist_ch      <= dch_d;
         dist_valid   <= valid_d;
         dist_timeout <= dtmo_d;
         dist_all     <= all_d;
      end
   end

endmodule
